// File: rtl/decoder_pipe_pkg.sv
// dec_pkg: shared types and defaults for the decoder_pipe block.
//   dec_types#(NUM_OUT)::dec_beat_t  - one stored beat: decoded vector plus range-error flag.
//   DEC_DEFAULT_NUM_OUT              - default output count (32 register write enables).
package dec_pkg;

  localparam int DEC_DEFAULT_NUM_OUT = 32;

  // The beat width follows NUM_OUT, so the struct is wrapped in a parameterised class
  // and each user picks it up as dec_types#(NUM_OUT)::dec_beat_t.
  virtual class dec_types #(parameter int NUM_OUT = DEC_DEFAULT_NUM_OUT);
    typedef struct packed {
      logic [NUM_OUT-1:0] onehot;
      logic               err;
    } dec_beat_t;
  endclass

endpackage

// File: rtl/decoder_pipe_onehot_decoder.sv
// onehot_decoder: combinational select-to-one-hot decoder with range-error detection.
// Ports:
//   sel    in   SEL_W    index to decode
//   en     in   1        enable; 0 forces an all-zero vector and no error
//   onehot out  NUM_OUT  bit sel set iff en && sel < NUM_OUT
//   err    out  1        en && sel >= NUM_OUT
// Optional feature: DECODER_PIPE_ZERO_MASK_EN forces bit 0 low for every beat
// (register x0 is never written) without raising err.
module onehot_decoder #(
  parameter int NUM_OUT = 32,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] onehot,
  output logic               err
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      onehot[i] = en && (int'(sel) == i);
    end
`ifdef DECODER_PIPE_ZERO_MASK_EN
    onehot[0] = 1'b0;
`endif
    // Always false when NUM_OUT == 2**SEL_W.
    err = en && (int'(sel) >= NUM_OUT);
  end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: pipelined one-hot decoder with valid/ready on both sides, a registered
// output stage (OUT) and a one-entry skid register (SKID) for full throughput under
// backpressure, plus sticky and saturating range-error reporting.
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        input beat valid
//   in_ready   out  1        block can accept a beat (registered, = !skid_full)
//   in_sel     in   SEL_W    index to decode
//   in_en      in   1        enable; 0 decodes to all-zero
//   out_valid  out  1        output beat valid
//   out_ready  in   1        downstream accepts the beat
//   out_onehot out  NUM_OUT  decoded vector
//   out_err    out  1        beat had in_en=1 and in_sel>=NUM_OUT
//   err_sticky out  1        set by any accepted error beat, cleared by rst
//   err_count  out  CNT_W    accepted error beats, saturating
// Optional feature: DECODER_PIPE_ZERO_MASK_EN (applied inside onehot_decoder).
module decoder_pipe
  import dec_pkg::*;
#(
  parameter int NUM_OUT = DEC_DEFAULT_NUM_OUT,
  parameter int SEL_W   = $clog2(NUM_OUT),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic               out_err,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   err_count
);

  typedef dec_types#(NUM_OUT)::dec_beat_t beat_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [NUM_OUT-1:0] dec_onehot_p0;
  logic               dec_err_p0;
  beat_t              dec_p0;
  beat_t              out_p1;
  beat_t              skid_p1;
  logic               vld_p1;
  logic               skid_vld_p1;
  logic               rdy_p1;
  logic [CNT_W-1:0]   cnt_p1;
  logic               sticky_p1;

  logic accept;
  logic out_free;
  logic vld_n;
  logic skid_vld_n;
  logic load_out_skid;
  logic load_out_in;
  logic load_skid;

  // ---- p0: decode ahead of the registers ----
  onehot_decoder #(
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) u_dec (
    .sel    (in_sel),
    .en     (in_en),
    .onehot (dec_onehot_p0),
    .err    (dec_err_p0)
  );

  assign dec_p0 = {dec_onehot_p0, dec_err_p0};

  assign accept   = in_valid && rdy_p1;
  assign out_free = !vld_p1 || out_ready;

  // SKID only fills while OUT is held, and in_ready is low whenever SKID is full, so a
  // SKID-to-OUT move never coincides with a new accept.
  always_comb begin
    vld_n         = vld_p1;
    skid_vld_n    = skid_vld_p1;
    load_out_skid = 1'b0;
    load_out_in   = 1'b0;
    load_skid     = 1'b0;
    if (out_free) begin
      if (skid_vld_p1) begin
        vld_n         = 1'b1;
        skid_vld_n    = 1'b0;
        load_out_skid = 1'b1;
      end else begin
        vld_n       = accept;
        load_out_in = accept;
      end
    end else if (accept) begin
      skid_vld_n = 1'b1;
      load_skid  = 1'b1;
    end
  end

  // ---- p1: OUT / SKID registers and error counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
      sticky_p1   <= 1'b0;
      cnt_p1      <= '0;
    end else begin
      vld_p1      <= vld_n;
      skid_vld_p1 <= skid_vld_n;
      rdy_p1      <= !skid_vld_n;
      if (accept && dec_err_p0) begin
        sticky_p1 <= 1'b1;
        cnt_p1    <= sat_inc(cnt_p1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_out_skid) begin
      out_p1 <= skid_p1;
    end else if (load_out_in) begin
      out_p1 <= dec_p0;
    end
    if (load_skid) begin
      skid_p1 <= dec_p0;
    end
  end

  // Payload registers carry no reset; qualifying with valid keeps the outputs at zero
  // after reset and whenever no beat is presented.
  assign out_valid  = vld_p1;
  assign in_ready   = rdy_p1;
  assign out_onehot = vld_p1 ? out_p1.onehot : '0;
  assign out_err    = vld_p1 && out_p1.err;
  assign err_sticky = sticky_p1;
  assign err_count  = cnt_p1;

endmodule
